demux_128_hs: RTL and testbench
===============================

DEMUX_128_HS -- requirements
Module: demux_128_hs

Interface
REQ-001 Parameter DATA_W, default 128: width of data path and all data ports.
REQ-002 Parameter CNT_W, default 16: width of per-output transfer counters.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream block present.
REQ-006 in_sel  input  1  destination: 0 -> port 0, 1 -> port 1; meaningful only while in_valid=1.
REQ-007 in_data  input  DATA_W  upstream 128-bit AES state/block.
REQ-008 in_ready  output  1  block accepted when in_valid & in_ready at rising edge.
REQ-009 flush  input  1  synchronous clear of both output slots.
REQ-010 out0_valid / out1_valid  output  1  slot n holds a block.
REQ-011 out0_ready / out1_ready  input  1  downstream n accepts when valid & ready.
REQ-012 out0_data / out1_data  output  DATA_W  slot n contents.
REQ-013 cnt0 / cnt1  output  CNT_W  count of blocks delivered on port n (downstream handshakes).

Function
REQ-014 Each output port SHALL own a one-entry register slot (data + full flag); outn_valid = slot n full, outn_data = slot n data register.
REQ-015 in_ready SHALL equal (!full[in_sel] | outsel_ready) & !flush, combinational from in_sel and the selected port state only.
REQ-016 On accept, in_data SHALL be written into slot in_sel; outn_valid rises the following cycle (latency 1).
REQ-017 Simultaneous drain of slot n and accept into slot n SHALL leave slot n full with the new data; no bubble, no loss.
REQ-018 Drain without accept SHALL clear full[n] next cycle; accept into slot n SHALL NOT disturb slot 1-n.
REQ-019 outn_data and outn_valid SHALL remain stable while outn_valid=1 and outn_ready=0.
REQ-020 cntn SHALL increment by 1 on each outn_valid & outn_ready cycle, wrapping from 2^CNT_W-1 to 0 without flag.
REQ-021 flush=1 SHALL clear full[0] and full[1] on the next edge, force in_ready=0 that cycle, leave data registers and counters unchanged; a downstream handshake coinciding with flush still counts.
REQ-022 Data registers SHALL load only on accept (no load when idle).

Reset
REQ-023 While rst=1: full[0]=full[1]=0, out0_valid=out1_valid=0, cnt0=cnt1=0, out0_data=out1_data=0, asynchronously.
REQ-024 in_ready SHALL be 1 in the first cycle after rst deasserts (slots empty, flush=0).
REQ-025 Reset asserted mid-transfer SHALL discard held blocks; no partial state survives.

Structure
REQ-026 Package demux_128_pkg SHALL hold DATA_W, CNT_W defaults and the port-index constants PORT0=0, PORT1=1.
REQ-027 A sub-module out_slot_128 (one-entry slot: load, drain, flush, full, data, counter) SHALL be instantiated twice; top holds only routing and in_ready logic.

Verification
REQ-028 Reset then in_valid=1, in_sel=0, in_data=0x00112233445566778899AABBCCDDEEFF, out0_ready=1 -> out0_valid=1 next cycle with that data, cnt0=1 one cycle later, out1_valid stays 0.
REQ-029 out1_ready=0, send two blocks to port 1 (0x69C4E0D86A7B0430D8CDB78070B4C55A then 0x...01) -> first accepted, in_ready=0 for second while in_sel=1; in_ready=1 if in_sel switched to 0.
REQ-030 Slot 0 full, out0_ready=1 and new accept to port 0 in same cycle -> out0_valid stays 1, data replaced, cnt0 +1, no idle cycle across 8 back-to-back blocks.
REQ-031 Preload cnt1 to 0xFFFF via 65535 transfers, one more transfer -> cnt1=0x0000.
REQ-032 Both slots full, flush=1 one cycle -> both valid 0 next cycle, in_ready=0 during flush, counters unchanged.
REQ-033 rst asserted asynchronously between edges while both slots full -> valids and counters 0 immediately, before next clk edge.

Source files
------------

// File: rtl/demux_128_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_128_pkg
// Description : Shared constants for the 128-bit 1:2 handshake demux.
//               Holds the default data/counter widths and the output port
//               index encoding used by in_sel.
// Revision    : 1.0  initial release
// ============================================================================
package demux_128_pkg;

  // Default widths picked up by the interface and the design modules.
  localparam int DATA_W_DEFAULT = 128;
  localparam int CNT_W_DEFAULT  = 16;

  // in_sel encoding.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage : demux_128_pkg
`default_nettype wire

// File: rtl/demux_128_hs_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_128_hs_if
// Description : Bus bundle for demux_128_hs: one upstream valid/ready channel
//               with a destination select, two downstream valid/ready
//               channels, a flush strobe and the per-port delivery counters.
// Modports    : slave  - the demux (consumes upstream, drives downstream)
//               master - the environment around it
// Revision    : 1.0  initial release
// ============================================================================
interface demux_128_hs_if
  import demux_128_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) ();

  logic              in_valid;
  logic              in_sel;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              flush;

  logic              out0_valid;
  logic              out0_ready;
  logic [DATA_W-1:0] out0_data;
  logic [CNT_W-1:0]  cnt0;

  logic              out1_valid;
  logic              out1_ready;
  logic [DATA_W-1:0] out1_data;
  logic [CNT_W-1:0]  cnt1;

  modport slave (
    input  in_valid, in_sel, in_data, flush, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, cnt0, out1_valid, out1_data, cnt1
  );

  modport master (
    output in_valid, in_sel, in_data, flush, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, cnt0, out1_valid, out1_data, cnt1
  );

endinterface : demux_128_hs_if
`default_nettype wire

// File: rtl/demux_128_hs_slot.sv
`default_nettype none
// ============================================================================
// Module      : out_slot_128
// Description : One-entry output register slot with delivery counter.
// Ports       : clk, rst        - clock, async active-high reset
//               i_load, i_data  - write a new block (caller guarantees room)
//               i_flush         - drop the held block on the next edge
//               i_ready         - downstream ready
//               o_valid, o_data - slot full flag and contents
//               o_cnt           - number of downstream handshakes (wraps)
//               o_can_accept    - slot can take a block this cycle
// Revision    : 1.0  initial release
// ============================================================================
module out_slot_128
  import demux_128_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_load,
  input  wire logic [DATA_W-1:0] i_data,
  input  wire logic              i_flush,
  input  wire logic              i_ready,
  output logic                   o_valid,
  output logic      [DATA_W-1:0] o_data,
  output logic      [CNT_W-1:0]  o_cnt,
  output logic                   o_can_accept
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              r_full;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_drain;

  assign w_drain      = r_full & i_ready;
  // Room exists when empty, or when the current block leaves this same edge.
  assign o_can_accept = ~r_full | i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      // A handshake concurrent with flush still counts as a delivery.
      if (w_drain) begin
        r_cnt <= r_cnt + C_CNT_ONE;
      end
      if (i_flush) begin
        r_full <= 1'b0;
      end else if (i_load) begin
        r_full <= 1'b1;
      end else if (w_drain) begin
        r_full <= 1'b0;
      end
      if (i_load) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_full;
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;

endmodule : out_slot_128
`default_nettype wire

// File: rtl/demux_128_hs.sv
`default_nettype none
// ============================================================================
// Module      : demux_128_hs
// Description : 1:2 demultiplexer for 128-bit blocks with valid/ready
//               handshakes. Each destination owns a one-entry slot; upstream
//               ready depends only on the selected slot so one stalled port
//               never blocks traffic to the other.
// Ports       : clk  - clock
//               rst  - async active-high reset
//               bus  - demux_128_hs_if.slave (upstream, flush, two outputs,
//                      per-port delivery counters)
// Revision    : 1.0  initial release
// ============================================================================
module demux_128_hs
  import demux_128_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input wire logic       clk,
  input wire logic       rst,
  demux_128_hs_if.slave  bus
);

  logic w_can0;
  logic w_can1;
  logic w_in_ready;
  logic w_accept;
  logic w_load0;
  logic w_load1;

  assign w_in_ready = ((bus.in_sel == PORT1) ? w_can1 : w_can0) & ~bus.flush;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_load0    = w_accept & (bus.in_sel == PORT0);
  assign w_load1    = w_accept & (bus.in_sel == PORT1);
  assign bus.in_ready = w_in_ready;

  out_slot_128 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot0 (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load0),
    .i_data       (bus.in_data),
    .i_flush      (bus.flush),
    .i_ready      (bus.out0_ready),
    .o_valid      (bus.out0_valid),
    .o_data       (bus.out0_data),
    .o_cnt        (bus.cnt0),
    .o_can_accept (w_can0)
  );

  out_slot_128 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot1 (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load1),
    .i_data       (bus.in_data),
    .i_flush      (bus.flush),
    .i_ready      (bus.out1_ready),
    .o_valid      (bus.out1_valid),
    .o_data       (bus.out1_data),
    .o_cnt        (bus.cnt1),
    .o_can_accept (w_can1)
  );

endmodule : demux_128_hs
`default_nettype wire

// File: tb/tb_demux_128_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_128_hs
// Description : Self-checking bench for demux_128_hs. A queue per output port
//               holds the blocks expected there; accepts push, downstream
//               handshakes pop and compare. Counters and ready are modelled
//               independently of the design.
// Revision    : 1.0  initial release
// ============================================================================
module tb_demux_128_hs;

  localparam logic [127:0] C_K1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] C_K2 = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  localparam logic [127:0] C_K3 = 128'h00000000000000000000000000000001;

  logic clk;
  logic rst;

  demux_128_hs_if #(.DATA_W(128), .CNT_W(16)) bus ();

  demux_128_hs #(.DATA_W(128), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] q0[$];
  logic [127:0] q1[$];
  logic [15:0]  m_cnt0 = '0;
  logic [15:0]  m_cnt1 = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a falling edge after inputs are driven: checks current outputs
  // against the model, advances the model by the coming rising edge, then
  // moves on to the next falling edge.
  task automatic step();
    logic f0, f1, er;
    #2;
    f0 = (q0.size() != 0);
    f1 = (q1.size() != 0);
    er = (bus.in_sel ? (!f1 || bus.out1_ready) : (!f0 || bus.out0_ready)) && !bus.flush;
    chk("in_ready", bus.in_ready, er);
    chk("out0_valid", bus.out0_valid, f0);
    chk("out1_valid", bus.out1_valid, f1);
    if (f0) chk("out0_data", bus.out0_data, q0[0]);
    if (f1) chk("out1_data", bus.out1_data, q1[0]);
    chk("cnt0", bus.cnt0, m_cnt0);
    chk("cnt1", bus.cnt1, m_cnt1);
    if (f0 && bus.out0_ready) begin void'(q0.pop_front()); m_cnt0 = m_cnt0 + 16'd1; end
    if (f1 && bus.out1_ready) begin void'(q1.pop_front()); m_cnt1 = m_cnt1 + 16'd1; end
    if (bus.flush) begin q0.delete(); q1.delete(); end
    if (bus.in_valid && er) begin
      if (bus.in_sel) q1.push_back(bus.in_data);
      else            q0.push_back(bus.in_data);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_sel     = 1'b0;
    bus.in_data    = '0;
    bus.flush      = 1'b0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    m_cnt0 = '0;
    m_cnt1 = '0;
  endtask

  task automatic send(input logic sel, input logic [127:0] d);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = d;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out0_valid", bus.out0_valid, 1'b0);
    chk("rst_out1_valid", bus.out1_valid, 1'b0);
    chk("rst_cnt0", bus.cnt0, 16'h0);
    chk("rst_cnt1", bus.cnt1, 16'h0);
    chk("rst_out0_data", bus.out0_data, 128'h0);
    chk("rst_out1_data", bus.out1_data, 128'h0);
    rst = 1'b0;
    model_clear();

    // First block to port 0 with the sink ready.
    chk("ready_after_rst", bus.in_ready, 1'b1);
    send(1'b0, C_K1);
    bus.out0_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("k1_out0_valid", bus.out0_valid, 1'b1);
    chk("k1_out0_data", bus.out0_data, C_K1);
    chk("k1_out1_idle", bus.out1_valid, 1'b0);
    step();
    chk("k1_cnt0", bus.cnt0, 16'd1);
    step();

    // Port 1 stalled: second block refused while aimed at port 1.
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    send(1'b1, C_K2);
    step();
    send(1'b1, C_K3);
    step();
    chk("stall_ready_sel1", bus.in_ready, 1'b0);
    bus.in_sel = 1'b0;
    #1;
    chk("stall_ready_sel0", bus.in_ready, 1'b1);
    bus.in_sel = 1'b1;
    step();
    bus.out1_ready = 1'b1;
    step();
    step();
    bus.in_valid = 1'b0;
    step();
    step();

    // Eight back-to-back blocks into port 0 with continuous drain.
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, rnd128());
      step();
      chk("b2b_valid", bus.out0_valid, 1'b1);
    end
    bus.in_valid = 1'b0;
    step();
    step();

    // Drive cnt1 to all-ones, then one more delivery must wrap it to zero.
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b1;
    send(1'b1, rnd128());
    for (int i = 0; i < 70000 && m_cnt1 != 16'hFFFF; i++) begin
      bus.in_data = rnd128();
      step();
    end
    chk("cnt1_reach_ffff", m_cnt1, 16'hFFFF);
    chk("cnt1_at_ffff", bus.cnt1, 16'hFFFF);
    step();
    chk("cnt1_wrap", bus.cnt1, 16'h0000);
    bus.in_valid = 1'b0;
    step();
    step();

    // Flush with both slots full.
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    send(1'b0, rnd128());
    step();
    send(1'b1, rnd128());
    step();
    send(1'b0, rnd128());
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out0_valid", bus.out0_valid, 1'b0);
    chk("flush_out1_valid", bus.out1_valid, 1'b0);
    step();

    // Randomised traffic including flushes.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_sel     = 1'($urandom_range(0, 1));
      bus.in_data    = rnd128();
      bus.out0_ready = ($urandom_range(0, 2) != 0);
      bus.out1_ready = ($urandom_range(0, 2) != 0);
      bus.flush      = ($urandom_range(0, 15) == 0);
      step();
    end

    // Asynchronous reset between edges with both slots holding blocks.
    idle_inputs();
    send(1'b0, rnd128());
    step();
    send(1'b1, rnd128());
    step();
    bus.in_valid = 1'b0;
    step();
    chk("pre_arst_both_full", {bus.out0_valid, bus.out1_valid}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out0_valid", bus.out0_valid, 1'b0);
    chk("arst_out1_valid", bus.out1_valid, 1'b0);
    chk("arst_cnt0", bus.cnt0, 16'h0);
    chk("arst_cnt1", bus.cnt1, 16'h0);
    chk("arst_out0_data", bus.out0_data, 128'h0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_demux_128_hs
`default_nettype wire
